// File: rtl/fe_de_queue_pkg.sv
// Shared constants and entry type for the fetch->decode instruction queue.
package fe_de_pkg;

    localparam int FE_DE_XLEN  = 64;
    localparam int FE_DE_ILEN  = 32;
    localparam int FE_DE_DEPTH = 4;

    typedef struct packed {
        logic [FE_DE_XLEN-1:0] pc;
        logic [FE_DE_XLEN-1:0] npc;
        logic [FE_DE_ILEN-1:0] ir;
    } fe_de_entry_t;

endpackage

// File: rtl/fe_de_queue_mem.sv
// DEPTH x W register array: one write port, one asynchronous read port, data not reset.
module fe_de_queue_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 160
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [W-1:0]             i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [W-1:0]             o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Entry write on an accepted push.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fe_de_queue.sv
// Fetch->decode instruction queue. Optional statistics outputs under FE_DE_QUEUE_STATS_EN.
module fe_de_queue
    import fe_de_pkg::*;
#(
    parameter int DEPTH = FE_DE_DEPTH,
    parameter int XLEN  = FE_DE_XLEN,
    parameter int ILEN  = FE_DE_ILEN
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   FE_V,
    input  logic [XLEN-1:0]        FE_PC,
    input  logic [XLEN-1:0]        FE_NPC,
    input  logic [ILEN-1:0]        FE_IR,
    output logic                   FE_STALL,
    input  logic                   DE_STALL,
    input  logic                   FLUSH,
    output logic                   DE_V,
    output logic [XLEN-1:0]        DE_PC,
    output logic [XLEN-1:0]        DE_NPC,
    output logic [ILEN-1:0]        DE_IR,
    output logic [$clog2(DEPTH):0] COUNT
`ifdef FE_DE_QUEUE_STATS_EN
    ,
    output logic [31:0]            FULL_CYCLES,
    output logic [31:0]            FLUSH_COUNT
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int W  = 2 * XLEN + ILEN;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_nonempty;
    logic          r_seen;

    logic          w_push;
    logic          w_pop;
    logic          w_we;
    logic [CW-1:0] w_count_nxt;
    logic [W-1:0]  w_rdata;
    logic [XLEN-1:0] w_pc;
    logic [XLEN-1:0] w_npc;
    logic [ILEN-1:0] w_ir;

    assign w_push = FE_V && !r_full;
    assign w_pop  = r_nonempty && !DE_STALL;
    assign w_we   = w_push && !FLUSH;

    // Next occupancy; flush wins over push and pop.
    always_comb begin
        w_count_nxt = r_count;
        if (FLUSH) begin
            w_count_nxt = {CW{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Pointers, occupancy and the flags decoded from the next occupancy.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_wptr     <= {AW{1'b0}};
            r_rptr     <= {AW{1'b0}};
            r_count    <= {CW{1'b0}};
            r_full     <= 1'b0;
            r_nonempty <= 1'b0;
            r_seen     <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == FULL_CNT);
            r_nonempty <= (w_count_nxt != {CW{1'b0}});
            if (FLUSH) begin
                r_wptr <= {AW{1'b0}};
                r_rptr <= {AW{1'b0}};
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
            end
            // DE_* read as zero until the first entry lands after reset.
            if (w_we) begin
                r_seen <= 1'b1;
            end
        end
    end

    fe_de_queue_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_mem (
        .i_clk   (CLK),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata ({FE_PC, FE_NPC, FE_IR}),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign {w_pc, w_npc, w_ir} = w_rdata;

    assign DE_PC    = r_seen ? w_pc  : {XLEN{1'b0}};
    assign DE_NPC   = r_seen ? w_npc : {XLEN{1'b0}};
    assign DE_IR    = r_seen ? w_ir  : {ILEN{1'b0}};
    assign DE_V     = r_nonempty;
    assign FE_STALL = r_full;
    assign COUNT    = r_count;

`ifdef FE_DE_QUEUE_STATS_EN
    logic [31:0] r_full_cycles;
    logic [31:0] r_flush_count;

    // Saturating full-cycle and flush counters.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_full_cycles <= 32'h0000_0000;
            r_flush_count <= 32'h0000_0000;
        end else begin
            if (r_full && (r_full_cycles != 32'hFFFF_FFFF)) begin
                r_full_cycles <= r_full_cycles + 32'h0000_0001;
            end
            if (FLUSH && (r_flush_count != 32'hFFFF_FFFF)) begin
                r_flush_count <= r_flush_count + 32'h0000_0001;
            end
        end
    end

    assign FULL_CYCLES = r_full_cycles;
    assign FLUSH_COUNT = r_flush_count;
`else
    // Statistics counters are absent in this build.
`endif

endmodule

// File: tb/tb_fe_de_queue.sv
// Directed self-checking bench for fe_de_queue (DEPTH=4, XLEN=64, ILEN=32).
module tb_fe_de_queue;

    logic        CLK;
    logic        RESET;
    logic        FE_V;
    logic [63:0] FE_PC;
    logic [63:0] FE_NPC;
    logic [31:0] FE_IR;
    logic        FE_STALL;
    logic        DE_STALL;
    logic        FLUSH;
    logic        DE_V;
    logic [63:0] DE_PC;
    logic [63:0] DE_NPC;
    logic [31:0] DE_IR;
    logic [2:0]  COUNT;
`ifdef FE_DE_QUEUE_STATS_EN
    logic [31:0] FULL_CYCLES;
    logic [31:0] FLUSH_COUNT;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fe_de_queue #(.DEPTH(4), .XLEN(64), .ILEN(32)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .FE_V     (FE_V),
        .FE_PC    (FE_PC),
        .FE_NPC   (FE_NPC),
        .FE_IR    (FE_IR),
        .FE_STALL (FE_STALL),
        .DE_STALL (DE_STALL),
        .FLUSH    (FLUSH),
        .DE_V     (DE_V),
        .DE_PC    (DE_PC),
        .DE_NPC   (DE_NPC),
        .DE_IR    (DE_IR),
        .COUNT    (COUNT)
`ifdef FE_DE_QUEUE_STATS_EN
        ,
        .FULL_CYCLES (FULL_CYCLES),
        .FLUSH_COUNT (FLUSH_COUNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] pc);
        FE_V   = v;
        FE_PC  = pc;
        FE_NPC = pc + 64'd4;
        FE_IR  = 32'hA000_0000 + pc[31:0];
    endtask

    task automatic test_reset();
        RESET = 1'b0; FE_V = 1'b0; FE_PC = 64'd0; FE_NPC = 64'd0; FE_IR = 32'd0;
        DE_STALL = 1'b0; FLUSH = 1'b0;
        #23;
        n_tests++; if (DE_V !== 1'b0) begin n_fail++; $display("FAIL reset_de_v: got %b want 0", DE_V); end
        n_tests++; if (COUNT !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", COUNT); end
        n_tests++; if (FE_STALL !== 1'b0) begin n_fail++; $display("FAIL reset_fe_stall: got %b want 0", FE_STALL); end
        n_tests++; if (DE_PC !== 64'd0) begin n_fail++; $display("FAIL reset_de_pc: got %h want 0", DE_PC); end
        @(negedge CLK);
        RESET = 1'b1;
        tick();
    endtask

    task automatic test_reset_midstream();
        DE_STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h500 + 64'(4 * i));
            tick();
        end
        drive(1'b0, 64'd0);
        n_tests++; if (COUNT !== 3'd3) begin n_fail++; $display("FAIL mid_count_pre: got %0d want 3", COUNT); end
        #2 RESET = 1'b0;
        #1;
        n_tests++; if (DE_V !== 1'b0) begin n_fail++; $display("FAIL mid_rst_de_v: got %b want 0", DE_V); end
        n_tests++; if (COUNT !== 3'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", COUNT); end
        n_tests++; if (FE_STALL !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fe_stall: got %b want 0", FE_STALL); end
        n_tests++; if (DE_PC !== 64'd0) begin n_fail++; $display("FAIL mid_rst_de_pc: got %h want 0", DE_PC); end
        #2 RESET = 1'b1;
        DE_STALL = 1'b0;
        drive(1'b1, 64'h1000);
        tick();
        drive(1'b0, 64'd0);
        n_tests++; if (DE_PC !== 64'h1000) begin n_fail++; $display("FAIL mid_first_pc: got %h want 1000", DE_PC); end
        n_tests++; if (DE_V !== 1'b1) begin n_fail++; $display("FAIL mid_first_v: got %b want 1", DE_V); end
        n_tests++; if (COUNT !== 3'd1) begin n_fail++; $display("FAIL mid_first_count: got %0d want 1", COUNT); end
        tick();
        n_tests++; if (DE_V !== 1'b0) begin n_fail++; $display("FAIL mid_drain_v: got %b want 0", DE_V); end
    endtask

    task automatic test_ordering();
        logic [63:0] pc;
        DE_STALL = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc = 64'(4 * i);
            drive(1'b1, pc);
            tick();
            n_tests++; if (DE_PC !== pc) begin n_fail++; $display("FAIL order_pc[%0d]: got %h want %h", i, DE_PC, pc); end
            n_tests++; if (DE_NPC !== pc + 64'd4) begin n_fail++; $display("FAIL order_npc[%0d]: got %h want %h", i, DE_NPC, pc + 64'd4); end
            n_tests++; if (DE_IR !== 32'hA000_0000 + pc[31:0]) begin n_fail++; $display("FAIL order_ir[%0d]: got %h want %h", i, DE_IR, 32'hA000_0000 + pc[31:0]); end
            n_tests++; if (COUNT !== 3'd1) begin n_fail++; $display("FAIL order_count[%0d]: got %0d want 1", i, COUNT); end
        end
        drive(1'b0, 64'd0);
        tick();
        n_tests++; if (DE_V !== 1'b0) begin n_fail++; $display("FAIL order_empty: got %b want 0", DE_V); end
    endtask

    task automatic test_fill_backpressure();
        logic [2:0] exp_cnt;
        DE_STALL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h100 + 64'(4 * i));
            tick();
            exp_cnt = 3'(i + 1);
            n_tests++; if (COUNT !== exp_cnt) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, COUNT, exp_cnt); end
            n_tests++; if (FE_STALL !== (i == 3)) begin n_fail++; $display("FAIL fill_stall[%0d]: got %b want %b", i, FE_STALL, (i == 3)); end
        end
        drive(1'b1, 64'h110);
        tick();
        n_tests++; if (COUNT !== 3'd4) begin n_fail++; $display("FAIL full_refuse_count: got %0d want 4", COUNT); end
        n_tests++; if (DE_PC !== 64'h100) begin n_fail++; $display("FAIL full_head_hold: got %h want 100", DE_PC); end
        DE_STALL = 1'b0;
        tick();
        DE_STALL = 1'b1;
        n_tests++; if (FE_STALL !== 1'b0) begin n_fail++; $display("FAIL pop_unstall: got %b want 0", FE_STALL); end
        n_tests++; if (COUNT !== 3'd3) begin n_fail++; $display("FAIL pop_refuse_count: got %0d want 3", COUNT); end
        n_tests++; if (DE_PC !== 64'h104) begin n_fail++; $display("FAIL pop_head: got %h want 104", DE_PC); end
        tick();
        drive(1'b0, 64'd0);
        n_tests++; if (COUNT !== 3'd4) begin n_fail++; $display("FAIL retry_count: got %0d want 4", COUNT); end
        DE_STALL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (DE_PC !== 64'h108 + 64'(4 * i)) begin n_fail++; $display("FAIL drain_pc[%0d]: got %h want %h", i, DE_PC, 64'h108 + 64'(4 * i)); end
        end
        tick();
        n_tests++; if (DE_V !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", DE_V); end
    endtask

    task automatic test_back_to_back();
        DE_STALL = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'h200 + 64'(4 * i));
            tick();
        end
        DE_STALL = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            drive(1'b1, 64'h200 + 64'(4 * (j + 1)));
            tick();
            n_tests++; if (COUNT !== 3'd2) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d want 2", j, COUNT); end
            n_tests++; if (DE_PC !== 64'h200 + 64'(4 * j)) begin n_fail++; $display("FAIL b2b_pc[%0d]: got %h want %h", j, DE_PC, 64'h200 + 64'(4 * j)); end
        end
        drive(1'b0, 64'd0);
        tick();
        n_tests++; if (DE_PC !== 64'h22C) begin n_fail++; $display("FAIL b2b_tail: got %h want 22c", DE_PC); end
        tick();
        n_tests++; if (COUNT !== 3'd0) begin n_fail++; $display("FAIL b2b_empty: got %0d want 0", COUNT); end
    endtask

    task automatic test_flush();
        DE_STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'h300 + 64'(4 * i));
            tick();
        end
        n_tests++; if (COUNT !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", COUNT); end
        drive(1'b1, 64'h3F0);
        DE_STALL = 1'b0;
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        drive(1'b0, 64'd0);
        n_tests++; if (COUNT !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", COUNT); end
        n_tests++; if (DE_V !== 1'b0) begin n_fail++; $display("FAIL flush_de_v: got %b want 0", DE_V); end
        n_tests++; if (DE_PC === 64'h3F0) begin n_fail++; $display("FAIL flush_dropped: got %h want not 3f0", DE_PC); end
        tick();
        n_tests++; if (DE_V !== 1'b0) begin n_fail++; $display("FAIL flush_stay_empty: got %b want 0", DE_V); end
        drive(1'b1, 64'h400);
        tick();
        drive(1'b0, 64'd0);
        n_tests++; if (DE_PC !== 64'h400) begin n_fail++; $display("FAIL flush_next_pc: got %h want 400", DE_PC); end
        n_tests++; if (COUNT !== 3'd1) begin n_fail++; $display("FAIL flush_next_count: got %0d want 1", COUNT); end
        tick();
    endtask

`ifdef FE_DE_QUEUE_STATS_EN
    task automatic test_stats();
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        n_tests++; if (FULL_CYCLES !== 32'd0) begin n_fail++; $display("FAIL stats_rst_full: got %0d want 0", FULL_CYCLES); end
        @(negedge CLK);
        RESET = 1'b1;
        DE_STALL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'h600 + 64'(4 * i));
            tick();
        end
        drive(1'b0, 64'd0);
        n_tests++; if (FULL_CYCLES !== 32'd0) begin n_fail++; $display("FAIL stats_full_start: got %0d want 0", FULL_CYCLES); end
        for (int i = 0; i < 6; i++) tick();
        FLUSH = 1'b1;
        tick();
        tick();
        FLUSH = 1'b0;
        tick();
        n_tests++; if (FULL_CYCLES !== 32'd7) begin n_fail++; $display("FAIL stats_full_cycles: got %0d want 7", FULL_CYCLES); end
        n_tests++; if (FLUSH_COUNT !== 32'd2) begin n_fail++; $display("FAIL stats_flush_count: got %0d want 2", FLUSH_COUNT); end
        DE_STALL = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_reset_midstream();
        test_ordering();
        test_fill_backpressure();
        test_back_to_back();
        test_flush();
`ifdef FE_DE_QUEUE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
